// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: WB writes win, multi-cycle results bypass or queue in a small FIFO.
// Optional saturating stall/kill counters are built when RF_ARB_STATS_EN is defined.
module rf_write_arbiter #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wb_we,
  input  logic [4:0]       wb_rd,
  input  logic [WIDTH-1:0] wb_data,
  input  logic             mc_valid,
  input  logic [4:0]       mc_rd,
  input  logic [WIDTH-1:0] mc_data,
  output logic             mc_ready,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [WIDTH-1:0] rf_wdata,
  output logic [31:0]      pend_mask,
  output logic             busy
`ifdef RF_ARB_STATS_EN
  ,
  output logic [15:0]      stall_cnt,
  output logic [15:0]      kill_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [4:0]       r_rd   [DEPTH];
  logic [WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [PW-1:0]    r_rptr;
  logic [PW-1:0]    r_wptr;
  logic [CW-1:0]    r_count;

  logic             w_wb_hit;
  logic             w_empty;
  logic             w_full;
  logic             w_bypass;
  logic             w_pop;
  logic             w_push;
  logic [DEPTH-1:0] w_kill;
  logic [31:0]      w_slot_mask [DEPTH];
  logic [31:0]      w_pend;

  assign w_wb_hit = wb_we && (wb_rd != 5'd0);
  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == FULL_CNT);
  assign w_bypass = !w_wb_hit && w_empty && mc_valid && (mc_rd != 5'd0);
  assign mc_ready = !reset && !w_full;
  assign w_push   = mc_valid && mc_ready && (mc_rd != 5'd0) && !w_bypass;
  // Dead (WAW-killed) heads are popped too, just without a port write.
  assign w_pop    = !w_wb_hit && !w_empty;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    assign w_kill[gi]      = w_wb_hit && r_vld[gi] && (r_rd[gi] == wb_rd);
    assign w_slot_mask[gi] = r_vld[gi] ? (32'd1 << r_rd[gi]) : 32'd0;
  end

  always_comb begin
    w_pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_pend = w_pend | w_slot_mask[i];
    end
  end

  assign pend_mask = reset ? 32'd0 : w_pend;
  assign busy      = !reset && (|r_vld);

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (!reset) begin
      if (w_wb_hit) begin
        rf_we    = 1'b1;
        rf_waddr = wb_rd;
        rf_wdata = wb_data;
      end else if (!w_empty) begin
        if (r_vld[r_rptr]) begin
          rf_we    = 1'b1;
          rf_waddr = r_rd[r_rptr];
          rf_wdata = r_data[r_rptr];
        end
      end else if (w_bypass) begin
        rf_we    = 1'b1;
        rf_waddr = mc_rd;
        rf_wdata = mc_data;
      end
    end
  end

  // Payload needs no reset: it is only ever observed through a set valid bit.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd[r_wptr]   <= mc_rd;
      r_data[r_wptr] <= mc_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld   <= '0;
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_kill[i]) r_vld[i] <= 1'b0;
      end
      if (w_pop) begin
        r_vld[r_rptr] <= 1'b0;
        r_rptr        <= r_rptr + 1'b1;
      end
      // Pushed after the kill so a same-cycle WB to the same rd leaves it valid.
      if (w_push) begin
        r_vld[r_wptr] <= 1'b1;
        r_wptr        <= r_wptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef RF_ARB_STATS_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_kill_cnt;
  logic [16:0] w_kill_sum;

  always_comb begin
    w_kill_sum = {1'b0, r_kill_cnt};
    for (int i = 0; i < DEPTH; i++) begin
      w_kill_sum = w_kill_sum + {16'd0, w_kill[i]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_kill_cnt  <= '0;
    end else begin
      if (mc_valid && !mc_ready && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
      r_kill_cnt <= w_kill_sum[16] ? 16'hFFFF : w_kill_sum[15:0];
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign kill_cnt  = r_kill_cnt;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized + directed scoreboard bench for rf_write_arbiter against a queue-based reference model.
module tb_rf_write_arbiter;
  localparam int DEPTH = 2;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             wb_we = 1'b0;
  logic [4:0]       wb_rd = '0;
  logic [WIDTH-1:0] wb_data = '0;
  logic             mc_valid = 1'b0;
  logic [4:0]       mc_rd = '0;
  logic [WIDTH-1:0] mc_data = '0;
  logic             mc_ready;
  logic             rf_we;
  logic [4:0]       rf_waddr;
  logic [WIDTH-1:0] rf_wdata;
  logic [31:0]      pend_mask;
  logic             busy;
`ifdef RF_ARB_STATS_EN
  logic [15:0]      stall_cnt;
  logic [15:0]      kill_cnt;
`endif

  always #5 clk = ~clk;

  rf_write_arbiter #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .wb_we     (wb_we),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .mc_valid  (mc_valid),
    .mc_rd     (mc_rd),
    .mc_data   (mc_data),
    .mc_ready  (mc_ready),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .pend_mask (pend_mask),
    .busy      (busy)
`ifdef RF_ARB_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .kill_cnt  (kill_cnt)
`endif
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    bit          alive;
  } ent_t;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        ready;
    logic [31:0] pend;
    logic        busy;
  } exp_t;

  ent_t mq[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // One cycle of stimulus; the reference model predicts this cycle's port outputs.
  task automatic cycle(input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                       input logic mv, input logic [4:0] mr, input logic [31:0] md);
    exp_t e;
    ent_t n;
    bit   byp;
    @(posedge clk);
    #1;
    wb_we = wv; wb_rd = wr; wb_data = wd;
    mc_valid = mv; mc_rd = mr; mc_data = md;
    byp = 1'b0;
    e.we = 1'b0; e.addr = '0; e.data = '0;
    e.ready = (mq.size() < DEPTH);
    e.pend = '0; e.busy = 1'b0;
    foreach (mq[i]) if (mq[i].alive) begin
      e.pend[mq[i].rd] = 1'b1;
      e.busy = 1'b1;
    end
    if (wv && wr != 5'd0) begin
      e.we = 1'b1; e.addr = wr; e.data = wd;
      foreach (mq[i]) if (mq[i].alive && mq[i].rd == wr) mq[i].alive = 1'b0;
    end else if (mq.size() > 0) begin
      n = mq.pop_front();
      if (n.alive) begin
        e.we = 1'b1; e.addr = n.rd; e.data = n.data;
      end
    end else if (mv && mr != 5'd0) begin
      e.we = 1'b1; e.addr = mr; e.data = md;
      byp = 1'b1;
    end
    if (mv && e.ready && mr != 5'd0 && !byp) begin
      n.rd = mr; n.data = md; n.alive = 1'b1;
      mq.push_back(n);
    end
    exp_q.push_back(e);
    $display("cyc wb=%0d/r%0d mc=%0d/r%0d exp_we=%0d r%0d=%0h ready=%0d pend=%08h",
             wv, wr, mv, mr, e.we, e.addr, e.data, e.ready, e.pend);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  // Monitor: compares the port against the oldest prediction every negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rf_we", 64'(rf_we), 64'(e.we));
        if (e.we) begin
          chk("rf_waddr", 64'(rf_waddr), 64'(e.addr));
          chk("rf_wdata", 64'(rf_wdata), 64'(e.data));
        end
        chk("mc_ready", 64'(mc_ready), 64'(e.ready));
        chk("pend_mask", 64'(pend_mask), 64'(e.pend));
        chk("busy", 64'(busy), 64'(e.busy));
      end else begin
        chk("stray_write", 64'(rf_we), 64'd0);
      end
    end
  end

  initial begin
    #1;
    chk("reset_rf_we", 64'(rf_we), 64'd0);
    chk("reset_ready", 64'(mc_ready), 64'd0);
    chk("reset_pend", 64'(pend_mask), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    #20;
    @(negedge clk);
    reset = 1'b0;

    // Bypass into an empty FIFO.
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234);
    idle(1);
    // WB/MC conflict: mc queued, drained on the idle cycle.
    cycle(1'b1, 5'd3, 32'hAA, 1'b1, 5'd7, 32'hBB);
    idle(2);
    // Full FIFO under a continuous WB stream, then drain and late accept.
    cycle(1'b1, 5'd1, 32'h11, 1'b1, 5'd8, 32'h80);
    cycle(1'b1, 5'd1, 32'h12, 1'b1, 5'd9, 32'h90);
    cycle(1'b1, 5'd1, 32'h13, 1'b1, 5'd10, 32'hA0);
    cycle(1'b1, 5'd1, 32'h14, 1'b1, 5'd10, 32'hA0);
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 32'hA0);
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 32'hA0);
    idle(2);
    // WAW kill: queue r12, then a younger WB write to r12.
    cycle(1'b1, 5'd2, 32'h22, 1'b1, 5'd12, 32'hDEAD);
    cycle(1'b1, 5'd12, 32'h55, 1'b0, 5'd0, 32'h0);
    idle(2);
    // Same-cycle WB to r13 and enqueue for r13 keeps the new entry.
    cycle(1'b1, 5'd13, 32'h66, 1'b1, 5'd13, 32'h77);
    idle(2);
    // Zero register: discarded mc result, and wb_rd==0 does not block draining.
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h99);
    cycle(1'b1, 5'd4, 32'h44, 1'b1, 5'd6, 32'h66);
    cycle(1'b1, 5'd0, 32'hF0, 1'b0, 5'd0, 32'h0);
    idle(2);

    // Mid-operation asynchronous reset with two entries queued.
    cycle(1'b1, 5'd1, 32'h1, 1'b1, 5'd20, 32'h200);
    cycle(1'b1, 5'd2, 32'h2, 1'b1, 5'd21, 32'h210);
    @(posedge clk);
    #1;
    wb_we = 1'b0; wb_rd = '0; mc_valid = 1'b0; mc_rd = '0;
    #1;
    chk("pre_reset_we", 64'(rf_we), 64'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("async_rf_we", 64'(rf_we), 64'd0);
    chk("async_busy", 64'(busy), 64'd0);
    chk("async_pend", 64'(pend_mask), 64'd0);
    chk("async_ready", 64'(mc_ready), 64'd0);
    mq.delete();
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    idle(3);

    // Randomized traffic with a narrow rd range so kills and collisions are frequent.
    for (int n = 0; n < 3000; n++) begin
      cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
    end
    idle(4);
    @(negedge clk);
    #1;
    chk("exp_queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Sits in front of the register file's single write port.
- Merges two writer streams:
  - the in-order WB-stage writeback, which is never stalled;
  - results from multi-cycle units (MUL/DIV, late loads), delivered on a valid/ready handshake.
- Multi-cycle results that lose arbitration are buffered in a small FIFO and drained on idle WB cycles.
- Exports a pending-register mask so the ID-stage hazard unit can stall readers of queued destinations.

Parameters:
- DEPTH, 2, FIFO entries for deferred multi-cycle writes; power of 2, minimum 2.
- WIDTH, 32, data width of register writes.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- wb_we  input  1  WB-stage write request; always has priority.
- wb_rd  input  5  WB destination register.
- wb_data  input  WIDTH  WB write data.
- mc_valid  input  1  multi-cycle result valid.
- mc_rd  input  5  multi-cycle destination register.
- mc_data  input  WIDTH  multi-cycle result data.
- mc_ready  output  1  result accepted this cycle when mc_valid && mc_ready.
- rf_we  output  1  register-file write enable.
- rf_waddr  output  5  register-file write address.
- rf_wdata  output  WIDTH  register-file write data.
- pend_mask  output  32  bit r set = a valid FIFO entry targets register r.
- busy  output  1  FIFO holds at least one valid entry.

Behaviour:
- Reset (asynchronous):
  - Clear all entry valid bits, read pointer and write pointer.
  - While reset is high, force rf_we=0, mc_ready=0, pend_mask=0, busy=0.
- Write-port select is combinational, so a WB write lands in the same cycle with zero added latency. Priority per cycle:
  1. wb_we && wb_rd!=0: drive WB fields. FIFO does not pop.
  2. Else if FIFO non-empty: drive head entry; pop at posedge.
  3. Else if FIFO empty && mc_valid && mc_rd!=0: bypass mc fields directly to the port; no enqueue.
  4. Else rf_we=0. Drive rf_waddr/rf_wdata to 0.
- wb_we with wb_rd==0 counts as no WB write and does not block the FIFO.
- mc_ready = !full. Acceptance does not depend on a same-cycle pop.
- Enqueue at posedge when mc_valid && mc_ready && mc_rd!=0 and the result was not bypassed (case 3).
- A result with mc_rd==0 is accepted (handshake completes) and discarded.
- FIFO is circular:
  - pointers wrap modulo DEPTH;
  - occupancy counter ranges 0..DEPTH;
  - simultaneous push and pop keeps occupancy unchanged.
- Order: FIFO drains strictly in acceptance order. A bypass is only allowed when the FIFO is empty, so ordering is preserved.
- WAW kill: when a WB write to register r occurs (case 1), every valid FIFO entry with rd==r is invalidated at that posedge, because the WB instruction is younger.
  - Invalidated entries stay in their slot.
  - The head skips them: an invalid head is popped without asserting rf_we, in any cycle where no WB write is present.
- Same-cycle WB write to r and enqueue of an mc entry for r: the new entry is stored valid, because it arrives after the WB write.
- pend_mask: OR of one-hot(rd) over valid entries, registered state only. busy = any valid entry.
- Mid-operation reset: all queued writes are lost. No partial write to the register file is ever emitted.

Optional Feature:
- Macro: RF_ARB_STATS_EN.
- Defined:
  - adds output stall_cnt (16 bits);
  - stall_cnt increments every cycle mc_valid && !mc_ready, and saturates at 16'hFFFF;
  - adds output kill_cnt (16 bits), counting WAW-invalidated entries and saturating;
  - both clear on reset.
- Undefined: neither port nor counter exists. Core behaviour is identical.

Test Plan:
- Bypass: FIFO empty, no WB; mc_valid=1, mc_rd=5, mc_data=32'h1234 -> same cycle rf_we=1, rf_waddr=5, rf_wdata=32'h1234; pend_mask stays 0.
- Conflict: wb_we=1 with rd=3, data=32'hAA, and mc rd=7, data=32'hBB in the same cycle -> port writes r3=AA; next cycle pend_mask=32'h80; following idle cycle writes r7=BB and pend_mask returns to 0.
- Full: hold wb_we=1 (rd=1) for 4 cycles while offering mc results rd=8,9,10 -> two accepted; mc_ready=0 on the third; release WB -> r8 then r9 written on consecutive cycles, then r10 is accepted.
- WAW kill: queue rd=12; next cycle WB writes r12=32'h55 -> entry killed, pend_mask bit12 clears; FIFO drains with no write to r12; final r12=32'h55.
- Zero register: mc_rd=0 -> mc_ready=1, no rf_we, no enqueue; wb_rd=0 with FIFO non-empty -> FIFO head drains that cycle.
- Reset: assert reset asynchronously with 2 entries queued -> rf_we, busy and pend_mask drop to 0 immediately; after release, no stale writes appear.
